// File: rtl/dbgapb_seq.sv
// dbgapb_seq: APB master expanding high-level debug commands into dbgapb register sequences
// Ports: pclk/presetn clock and synchronous active-low reset; cmd_* command request (accepted on
//        cmd_valid & cmd_ready); rsp_* one-cycle completion with read data and error flag;
//        psel/penable/pwrite/paddr/pstrb/pwdata/prdata/pready/pslverr APB master toward dbgapb.
module dbgapb_seq #(
  parameter int XLEN     = 64,
  parameter int POLL_MAX = 256
) (
  input  logic            pclk,
  input  logic            presetn,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_op,
  input  logic [11:0]     cmd_addr,
  input  logic [XLEN-1:0] cmd_wdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_rdata,
  output logic            rsp_err,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output logic [31:0]     paddr,
  output logic [3:0]      pstrb,
  output logic [31:0]     pwdata,
  input  logic [31:0]     prdata,
  input  logic            pready,
  input  logic            pslverr
);
  localparam logic [11:0] A_DBG_EN = 12'h000, A_INST = 12'h004, A_INST_WR = 12'h008;
  localparam logic [11:0] A_WDATA_L = 12'h00C, A_WDATA_H = 12'h010, A_WDATA_WR = 12'h014;
  localparam logic [11:0] A_RDATA_L = 12'h018, A_RDATA_H = 12'h01C;
  localparam logic [11:0] I_ATTACH = 12'h001, I_RESUME = 12'h002, I_GPR_RD = 12'h010;
  localparam logic [11:0] I_GPR_WR = 12'h011, I_CSR_RD = 12'h012, I_CSR_WR = 12'h013;
  localparam logic [11:0] I_PC_RD = 12'h014, I_INSTREG_WR = 12'h020, I_EXECUTE = 12'h021;
  localparam logic [11:0] I_STATUS_RD = 12'h022;
  localparam logic W64 = (XLEN == 64);
  localparam int PW = $clog2(POLL_MAX + 1);
  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;
  state_t r_state, w_next;
  logic [2:0] r_op, w_op;
  logic [11:0] r_addr, w_opc, w_a, w_mask;
  logic [63:0] r_wdata, r_rdata;
  logic [3:0] r_step, w_base, w_nstep;
  logic [PW-1:0] r_poll;
  logic [31:0] w_d;
  logic r_en, r_err, w_rd, w_wr, w_ex, w_w, w_last, w_busy, w_done, w_poll, w_halt, w_tmo;
  assign w_op   = (r_state == S_IDLE) ? cmd_op : r_op;
  assign w_rd   = (w_op == 3'd2) || (w_op == 3'd4) || (w_op == 3'd6);
  assign w_wr   = (w_op == 3'd3) || (w_op == 3'd5);
  assign w_ex   = (w_op == 3'd7);
  // Global step ladder: 0 DBG_EN, 1 WDATA_L, 2 WDATA_H, 3 WDATA_WR, 4-9 INST/INST_WR pairs
  // (command, EXECUTE, STATUS_RD), 10 RDATA_L (also the poll read), 11 RDATA_H.
  assign w_mask = {w_rd & W64, w_rd | w_ex, {4{w_ex}}, 2'b11, w_wr | w_ex, w_wr & W64, w_wr | w_ex, ~r_en};
  assign w_base = (r_state == S_IDLE) ? 4'd0 : r_step + 4'd1;
  always_comb begin
    w_nstep = 4'd0;
    w_last  = 1'b1;
    for (int k = 11; k >= 0; k--)
      if (w_mask[k] && 4'(k) >= w_base) begin
        w_nstep = 4'(k);
        w_last  = 1'b0;
      end
  end
  always_comb begin
    case (r_op)
      3'd0:    w_opc = I_ATTACH;
      3'd1:    w_opc = I_RESUME;
      3'd2:    w_opc = I_GPR_RD;
      3'd3:    w_opc = I_GPR_WR;
      3'd4:    w_opc = I_CSR_RD;
      3'd5:    w_opc = I_CSR_WR;
      3'd6:    w_opc = I_PC_RD;
      default: w_opc = I_INSTREG_WR;
    endcase
  end
  always_comb begin
    w_a = A_RDATA_H;
    w_w = 1'b1;
    w_d = 32'd1;
    case (r_step)
      4'd0:              w_a = A_DBG_EN;
      4'd1:              begin w_a = A_WDATA_L; w_d = r_wdata[31:0]; end
      4'd2:              begin w_a = A_WDATA_H; w_d = r_wdata[63:32]; end
      4'd3:              w_a = A_WDATA_WR;
      4'd4, 4'd6, 4'd8:  begin
        w_a = A_INST;
        w_d = {4'b0, r_addr, 4'b0, (r_step == 4'd4) ? w_opc : (r_step == 4'd6) ? I_EXECUTE : I_STATUS_RD};
      end
      4'd5, 4'd7, 4'd9:  w_a = A_INST_WR;
      4'd10:             begin w_a = A_RDATA_L; w_w = 1'b0; w_d = '0; end
      default:           begin w_w = 1'b0; w_d = '0; end
    endcase
  end
  assign w_busy  = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign psel    = w_busy;
  assign penable = (r_state == S_ACCESS);
  assign pwrite  = w_busy & w_w;
  assign paddr   = w_busy ? {20'b0, w_a} : 32'b0;
  assign pwdata  = pwrite ? w_d : 32'b0;
  assign pstrb   = pwrite ? 4'hF : 4'h0;
  assign cmd_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_err   = rsp_valid & r_err;
  assign rsp_rdata = rsp_valid ? r_rdata[XLEN-1:0] : '0;
  assign w_done = (r_state == S_ACCESS) && pready;
  assign w_poll = w_ex && (r_step == 4'd10);
  assign w_halt = prdata[1];
  // This read is the last one allowed when it would bring the count to POLL_MAX.
  assign w_tmo  = (r_poll == PW'(POLL_MAX - 1));
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = cmd_valid ? S_SETUP : S_IDLE;
      S_SETUP:  w_next = S_ACCESS;
      S_ACCESS: if (pready) w_next = (pslverr || (w_poll ? (w_halt || w_tmo) : w_last)) ? S_RESP : S_SETUP;
      default:  w_next = S_IDLE;
    endcase
  end
  always_ff @(posedge pclk) r_state <= presetn ? w_next : S_IDLE;
  always_ff @(posedge pclk)
    if (!presetn) begin
      r_en    <= 1'b0;
      r_err   <= 1'b0;
      r_poll  <= '0;
      r_step  <= '0;
      r_op    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else if (r_state == S_IDLE && cmd_valid) begin
      r_op    <= cmd_op;
      r_addr  <= cmd_addr;
      r_wdata <= 64'(cmd_wdata);
      r_step  <= w_nstep;
      r_poll  <= '0;
      r_err   <= 1'b0;
      r_rdata <= '0;
    end else if (w_done) begin
      if (pslverr) begin
        r_err   <= 1'b1;
        r_rdata <= '0;
      end else begin
        if (r_step == 4'd0) r_en <= 1'b1;
        if (w_rd && r_step == 4'd10) r_rdata[31:0] <= prdata;
        if (w_rd && r_step == 4'd11) r_rdata[63:32] <= prdata;
        if (w_poll && !w_halt) begin
          r_poll <= r_poll + 1'b1;
          r_err  <= w_tmo;
        end
        r_step <= w_poll ? r_step : w_nstep;
      end
    end
endmodule

// File: doc/dbgapb_seq.md
# dbgapb_seq

Debug command sequencer: APB master that turns single high-level debug commands (attach, resume, GPR/CSR/PC read, GPR/CSR write, execute instruction) into the register-level APB transaction sequence required by the `dbgapb` debug slave. It sits between a debug transport (JTAG DTM or host bridge) and the `dbgapb` APB port. It owns `DBG_EN` enabling, data staging, instruction issue, pready wait-states, result readback and post-execute halt polling.

## Interface
- `XLEN`, default 64: core data width; 32 or 64 only. 32 skips all `_H` accesses.
- `POLL_MAX`, default 256: maximum status polls after EXEC before timeout.
- `pclk`  in  1  clock.
- `presetn`  in  1  reset, synchronous, active-low.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  sequencer idle; the command is accepted on `cmd_valid & cmd_ready`.
- `cmd_op`  in  3  0 ATTACH, 1 RESUME, 2 GPR_RD, 3 GPR_WR, 4 CSR_RD, 5 CSR_WR, 6 PC_RD, 7 EXEC.
- `cmd_addr`  in  12  GPR index (bits [4:0]) or CSR address.
- `cmd_wdata`  in  XLEN  write data; for EXEC, the instruction is bits [31:0].
- `rsp_valid`  out  1  one-cycle completion pulse; there is no backpressure.
- `rsp_rdata`  out  XLEN  read result; 0 for non-read ops.
- `rsp_err`  out  1  completion with error; valid only with `rsp_valid`.
- `psel`, `penable`, `pwrite`  out  1  APB master controls.
- `paddr`  out  32  APB address: bits [11:0] are a `DBGAPB_*` offset from `dbgapb_mmap.h`, upper bits are 0.
- `pstrb`  out  4  always 4'hF on writes, 0 on reads.
- `pwdata`  out  32  write data.
- `prdata`  in  32  read data.
- `pready`  in  1  ready.
- `pslverr`  in  1  slave error.

## Operation
- The command is captured into internal registers on acceptance. `cmd_*` may change afterwards.
- Instruction word: `{4'b0, addr[11:0], 4'b0, code[11:0]}`. `code` is the matching `INST_*` value from `dbgapb_define.h`.
- Each command expands to an ordered step list. Every step is one APB transfer.
  - Step 0 is included only if the `en` flag is 0: write 1 to `DBG_EN`, then set `en`.
  - GPR_WR and CSR_WR: write `WDATA_L`, then `WDATA_H` (XLEN=64 only), then `WDATA_WR`=1, then write INST with code GPR_WR/CSR_WR, then `INST_WR`=1.
  - GPR_RD, CSR_RD and PC_RD: write INST, then `INST_WR`=1, then read `RDATA_L`, then read `RDATA_H` (XLEN=64 only).
  - ATTACH and RESUME: write INST, then `INST_WR`=1.
  - EXEC:
    - Load: write `WDATA_L`=instr, then `WDATA_WR`=1, then write INST=INSTREG_WR, then `INST_WR`=1.
    - Execute: write INST=EXECUTE, then `INST_WR`=1.
    - Poll: write INST=STATUS_RD, then `INST_WR`=1, then repeatedly read `RDATA_L` until bit1 (halted)=1.
- Poll counter: 0 at poll entry, incremented per `RDATA_L` read. Reaching `POLL_MAX` without halted=1 completes with `rsp_err`=1.
- Read results are assembled as `{H, L}`. For XLEN=32 the result is `L` only.
- An abort is triggered by `pslverr`=1 on any completing transfer. The remaining steps are skipped, `rsp_valid`=1 and `rsp_err`=1 are driven the next cycle, and `rsp_rdata`=0.
- Sequencer states:
  - IDLE → SETUP on accept.
  - SETUP → ACCESS unconditionally.
  - ACCESS holds while `pready`=0.
  - On `pready`=1, ACCESS → SETUP (next step), or → RESP (last step, error, or timeout).
  - RESP → IDLE.
- RESUME does not clear `en`. Only reset clears `en`.

## Timing
- Reset (sampled on the `pclk` edge with `presetn`=0) applies the following; an in-flight transfer is abandoned with no response:
  - outputs: `psel`=0, `penable`=0, `pwrite`=0, `paddr`=0, `pwdata`=0, `pstrb`=0, `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0, `cmd_ready`=1;
  - internal: `en`=0, state=IDLE, poll counter=0.
- The accept edge is followed by SETUP in the next cycle.
- SETUP: `psel`=1, `penable`=0; `paddr`, `pwrite`, `pwdata` and `pstrb` are stable from SETUP through the end of ACCESS.
- ACCESS: `psel`=1, `penable`=1.
- Back-to-back steps: SETUP follows a completed ACCESS immediately, with no idle cycle.
- `prdata` is sampled only in ACCESS with `pready`=1.
- With `pready` tied to 1, each step takes 2 cycles. Response latency is 2·steps+1 cycles after the accept edge.
- `cmd_ready`=0 from the accept edge until the cycle after `rsp_valid`. `cmd_valid` arriving during RESP is not accepted until IDLE.
- The poll counter saturates. Exactly `POLL_MAX` `RDATA_L` reads are issued before the timeout.

## Test plan
- Reset, then ATTACH with `pready`=1 → transfers: `DBG_EN`←1, INST←`INST_ATTACH`, `INST_WR`←1. `rsp_valid` arrives at cycle 7 after accept, `rsp_err`=0.
- Then GPR_RD with addr=5; slave returns L=0x89ABCDEF, H=0x01234567 → no `DBG_EN` write, INST=`{4'b0,12'h005,4'b0,INST_GPR_RD}`, `rsp_rdata`=0x0123456789ABCDEF.
- CSR_WR with addr=0x300, wdata=0xDEADBEEF_00000008, slave holding `pready`=0 for 2 cycles on `INST_WR` → `WDATA_L`=0x00000008, `WDATA_H`=0xDEADBEEF, `paddr`/`pwdata` stable through the wait, one `rsp_valid` with `rsp_err`=0.
- EXEC of 0x00000013, status halted=0 for 3 reads then 1 → 4 `RDATA_L` reads, `rsp_err`=0. With halted stuck at 0 and `POLL_MAX`=4 → exactly 4 reads, `rsp_err`=1.
- `pslverr`=1 on the `WDATA_WR` step of GPR_WR → no INST write is issued, `rsp_err`=1, `rsp_rdata`=0, `cmd_ready`=1 the following cycle.
- `presetn` low during ACCESS of a multi-step command → `psel`=0 and `penable`=0 after that edge, no `rsp_valid`, and the next ATTACH re-issues `DBG_EN`←1.
